// File: rtl/sine_dds_seq.sv
// Phase-accumulator sequencer: walks the sine ROM address bus and registers ROM data toward the DAC.
// Optional build macro SINE_DDS_TWOS_COMP_EN converts offset-binary samples to two's complement.
module sine_dds_seq #(
    parameter int PHASE_W = 24,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [PHASE_W-1:0] i_freq_word,
    input  logic [CNT_W-1:0]   i_n_cycles,
    output logic [7:0]         o_rom_addr,
    input  logic [7:0]         i_rom_q,
    output logic [7:0]         o_dac_data,
    output logic               o_dac_valid,
    output logic               o_busy,
    output logic               o_done
);

    // state   | meaning
    // S_IDLE  | phase/count held at 0, waiting for an accepted start
    // S_RUN   | accumulating phase, one ROM address per cycle
    // S_DRAIN | last sample registering, phase already back at 0
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_fw;
    logic [PHASE_W-1:0] w_phase_sum;
    logic               w_carry;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   w_count_inc;
    logic               r_stop_flag;
    logic               w_accept;
    logic               w_exit;
    logic [7:0]         w_sample;
    logic [7:0]         r_dac_data;
    logic               r_dac_valid;
    logic               r_done;

    assign {w_carry, w_phase_sum} = {1'b0, r_phase} + {1'b0, r_fw};
    assign w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_accept    = i_start & ~i_stop & (i_freq_word != '0);
    // A period end is the only place a run may stop, so no wrapped address is ever sampled.
    assign w_exit      = w_carry & (((r_n != '0) && (w_count_inc == r_n)) || r_stop_flag);

`ifdef SINE_DDS_TWOS_COMP_EN
    assign w_sample = {~i_rom_q[7], i_rom_q[6:0]};
`else
    assign w_sample = i_rom_q;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_exit) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase     <= '0;
            r_fw        <= '0;
            r_count     <= '0;
            r_n         <= '0;
            r_stop_flag <= 1'b0;
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_dac_valid <= (r_state == S_RUN);
            r_done      <= (r_state == S_DRAIN);
            if (r_state == S_RUN) r_dac_data <= w_sample;
            case (r_state)
                S_RUN: begin
                    if (w_exit) begin
                        r_phase     <= '0;
                        r_stop_flag <= 1'b0;
                    end else begin
                        r_phase <= w_phase_sum;
                        if (i_stop) r_stop_flag <= 1'b1;
                    end
                    if (w_carry) r_count <= w_count_inc;
                end
                default: begin
                    r_phase     <= '0;
                    r_count     <= '0;
                    r_stop_flag <= 1'b0;
                    if (r_state == S_IDLE && w_accept) begin
                        r_fw <= i_freq_word;
                        r_n  <= i_n_cycles;
                    end
                end
            endcase
        end
    end

    assign o_rom_addr  = r_phase[PHASE_W-1 -: 8];
    assign o_dac_data  = r_dac_data;
    assign o_dac_valid = r_dac_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_sine_dds_seq.sv
// Directed bench for sine_dds_seq with a behavioural ROM; honours SINE_DDS_TWOS_COMP_EN when defined.
module tb_sine_dds_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [23:0] freq_word;
    logic [15:0] n_cycles;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_q;
    logic [7:0]  dac_data;
    logic        dac_valid;
    logic        busy;
    logic        done;
    logic        ovr_en;
    logic [7:0]  ovr_val;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] rom_model(input logic [7:0] a);
        return ovr_en ? ovr_val : rom_f(a);
    endfunction

    function automatic logic [7:0] conv(input logic [7:0] q);
`ifdef SINE_DDS_TWOS_COMP_EN
        return {~q[7], q[6:0]};
`else
        return q;
`endif
    endfunction

    // Address expected in RUN cycle k (k=1 is the first RUN cycle, phase 0).
    function automatic logic [7:0] addr_at(input logic [23:0] fw, input int k);
        longint     p;
        logic [23:0] ph;
        p  = longint'(k - 1) * longint'(fw);
        ph = p[23:0];
        return ph[23:16];
    endfunction

    assign rom_q = ovr_en ? ovr_val : rom_f(rom_addr);

    sine_dds_seq #(.PHASE_W(24), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_freq_word (freq_word),
        .i_n_cycles  (n_cycles),
        .o_rom_addr  (rom_addr),
        .i_rom_q     (rom_q),
        .o_dac_data  (dac_data),
        .o_dac_valid (dac_valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"},  32'(rom_addr),  32'h0);
        check({tag, "_data"},  32'(dac_data),  32'h0);
        check({tag, "_valid"}, 32'(dac_valid), 32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
        check({tag, "_done"},  32'(done),      32'h0);
    endtask

    // Starts a run in the current cycle and checks every cycle through the done cycle.
    task automatic run_check(input string tag, input logic [23:0] fw, input logic [15:0] n,
                             input int len, input int stop_k, input int ign_k);
        logic [7:0] ea;
        freq_word = fw;
        n_cycles  = n;
        start     = 1'b1;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            ea = (k <= len) ? addr_at(fw, k) : 8'h00;
            check($sformatf("%s_busy_k%0d", tag, k),  32'(busy),      32'(k <= len + 1));
            check($sformatf("%s_done_k%0d", tag, k),  32'(done),      32'(k == len + 2));
            check($sformatf("%s_valid_k%0d", tag, k), 32'(dac_valid), 32'(k >= 2 && k <= len + 1));
            check($sformatf("%s_addr_k%0d", tag, k),  32'(rom_addr),  32'(ea));
            if (k >= 2 && k <= len + 1)
                check($sformatf("%s_data_k%0d", tag, k), 32'(dac_data),
                      32'(conv(rom_model(addr_at(fw, k - 1)))));
            if (k == 3) begin
                freq_word = 24'h123456;
                n_cycles  = 16'd7;
            end
            if (k == stop_k) stop  = 1'b1;
            if (k == ign_k)  start = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        freq_word = '0; n_cycles = '0;
        ovr_en = 1'b0; ovr_val = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // start with zero increment is ignored
        freq_word = 24'h0; n_cycles = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fw0_busy_a", 32'(busy), 32'h0);
        @(negedge clk);
        check("fw0_busy_b", 32'(busy), 32'h0);

        // start and stop together: stop wins
        freq_word = 24'h010000; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy_a", 32'(busy), 32'h0);
        @(negedge clk);
        check("startstop_busy_b", 32'(busy), 32'h0);

        // single period, with a start during RUN that must be ignored
        run_check("one", 24'h010000, 16'd1, 256, 0, 5);
        // two periods started in the done cycle; start during DRAIN ignored
        run_check("two", 24'h010000, 16'd2, 512, 0, 513);
        // continuous with a stop pulse, started in the done cycle
        run_check("stop", 24'h040000, 16'd0, 64, 10, 0);
        // three periods of two RUN cycles each
        run_check("three", 24'h800000, 16'd3, 6, 0, 0);

        // sample format with forced ROM values
        ovr_en = 1'b1; ovr_val = 8'h80;
        run_check("q80", 24'h400000, 16'd1, 4, 0, 0);
        ovr_val = 8'hFF;
        run_check("qff", 24'h400000, 16'd1, 4, 0, 0);
        ovr_en = 1'b0;
        @(negedge clk);
`ifdef SINE_DDS_TWOS_COMP_EN
        check("fmt_ff_data", 32'(dac_data), 32'h7F);
`else
        check("fmt_ff_data", 32'(dac_data), 32'hFF);
`endif

        // reset in the middle of a continuous run
        freq_word = 24'h010000; n_cycles = 16'd0; start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_addr", 32'(rom_addr), 32'd99);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        run_check("after_rst", 24'h400000, 16'd1, 4, 0, 0);
        @(negedge clk);
        check("final_busy", 32'(busy), 32'h0);
        check("final_done", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sine_dds_seq.md
# sine_dds_seq

Phase-accumulator sequencer that reads the 256×8 asynchronous sine ROM (`sinerom`) and streams samples to the STF test DAC path. A started run emits either a programmed number of full sine periods or an unbounded stream until stopped, with a start/busy/done handshake toward the STF register block. The sequencer owns the ROM address bus and registers the ROM data, so the ROM stays purely combinational between the two register stages.

## Interface
- `PHASE_W`, default 24: phase accumulator width; ROM address is the top 8 bits.
- `CNT_W`, default 16: width of the period counter and `n_cycles`.
- `CLK` in 1: sole clock; all logic is rising-edge.
- `RST` in 1: reset is synchronous and active-high.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `stop` in 1: level or pulse; ends a run at the next period boundary.
- `freq_word` in PHASE_W: phase increment, latched at accepted start.
- `n_cycles` in CNT_W: periods to emit, latched at start; 0 = continuous.
- `rom_addr` out 8: ROM address, equal to `phase[PHASE_W-1:PHASE_W-8]`.
- `rom_q` in 8: ROM data, combinational from `rom_addr`.
- `dac_data` out 8: registered sample.
- `dac_valid` out 1: `dac_data` holds a sample of the current run.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when a run completes normally.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: phase = 0, count = 0. `start`=1, `stop`=0, `freq_word`≠0 → latch `fw`/`n`, go to RUN. `start` with `freq_word`=0 is ignored. `start` and `stop` together in IDLE: `stop` wins and `start` is ignored.
- RUN: each cycle phase <= phase + fw, modulo 2^PHASE_W. A carry out of the MSB marks a period end, and count increments on it.
- RUN exit: on a carry where count+1 == n (n≠0), or on a carry while the stop flag is set, load phase with 0 and go to DRAIN. A sample at a wrapped address is never emitted.
- The stop flag is set by `stop`=1 in RUN and cleared on leaving RUN. `stop` is ignored in DRAIN and IDLE.
- DRAIN lasts one cycle, then returns to IDLE with `done`=1 in that IDLE cycle.
- `start` in RUN or DRAIN is ignored. Latched `fw`/`n` do not change mid-run.
- Counter arithmetic: count is CNT_W bits. In continuous mode it wraps silently and never terminates the run.
- `RST` in any state: IDLE on the next edge with all outputs at reset values. No `done` pulse is produced.

## Timing
- Reset values: `rom_addr`=0, `dac_data`=0, `dac_valid`=0, `busy`=0, `done`=0.
- Start accepted at edge T: cycle T+1 is in RUN, with `busy`=1, phase=0, `rom_addr`=0.
- Latency from address to data is 1 cycle: `dac_data`(t+1) = f(`rom_q`(t)), and `dac_valid`(t+1) = (state(t)==RUN).
- The first valid sample is at T+2. The last valid sample is in the DRAIN cycle.
- `done` is high for exactly one cycle, coincident with `busy` falling.
- The earliest re-accepted `start` is in the `done` cycle.
- Number of valid samples = number of RUN cycles.

## Configuration
- `SINE_DDS_TWOS_COMP_EN`
  - Defined: `dac_data` = {~rom_q[7], rom_q[6:0]}, converting offset-binary to two's complement.
  - Undefined: `dac_data` = `rom_q` unmodified.
- Timing and handshake behaviour are identical in both builds.

## Test plan
- Single period step: PHASE_W=24, fw=0x010000, n=1, start at T.
  - RUN T+1..T+256.
  - `rom_addr` steps 0..255.
  - 256 valid samples on T+2..T+257, equal to ROM[0..255].
  - DRAIN at T+257.
  - `done` and `busy`↓ at T+258.
- Two periods: fw=0x010000, n=2.
  - 512 valid samples.
  - `done` at T+514.
  - `rom_addr` wraps 255→0 exactly once mid-run.
- Continuous with stop: fw=0x040000, n=0, `stop` pulsed at T+10.
  - Run ends at the first carry, at T+64.
  - 64 valid samples.
  - `done` at T+66.
- Ignored requests:
  - `start` with fw=0 → `busy` stays 0.
  - `start`+`stop` together in IDLE → `busy` stays 0.
  - `start` at T+5 during a run → no effect on length.
- Reset mid-run: `RST` at T+100 in RUN.
  - Next cycle: all outputs 0, state IDLE, no `done` pulse.
  - A new `start` is accepted on the following cycle.
- Build with `SINE_DDS_TWOS_COMP_EN`: `rom_q`=0x80 → `dac_data`=0x00, and `rom_q`=0xFF → `dac_data`=0x7F.
